// File: rtl/cpu_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ifetch
// Description : Instruction fetch stage. Owns the fetch PC, issues word
//               fetches to instruction memory under a credit limit, buffers
//               in-order responses in a DEPTH-entry queue and presents the
//               queue head to decode. A taken P3 jump flushes the queue and
//               discards every fetch still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ifetch #(
  parameter logic [31:0] RESET_PC = 32'hFFFF_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc,
  output logic        p2_instr_valid,
  input  logic        p2_bubble,
  input  logic        p3_jump_taken,
  input  logic [31:0] p3_jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  // Pointer width indexes the DEPTH entries; counters need one extra bit
  // so that a completely full queue or DEPTH outstanding fetches fit.
  localparam int unsigned   C_AW        = $clog2(DEPTH);
  localparam int unsigned   C_CW        = C_AW + 1;
  localparam logic [C_CW:0] C_DEPTH_OCC = (C_CW + 1)'(DEPTH);
  localparam logic [C_CW-1:0] C_DEPTH_CNT = C_CW'(DEPTH);

  // Architectural fetch state
  logic [31:0]     fetch_pc_q,    fetch_pc_d;
  logic [C_CW-1:0] outstanding_q, outstanding_d;
  logic [C_CW-1:0] drop_q,        drop_d;

  // Decode queue bookkeeping
  logic [C_CW-1:0] count_q,  count_d;
  logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;

  // PC-tag FIFO: one entry per outstanding fetch, popped by every response
  logic [C_AW-1:0] tag_rd_q, tag_rd_d;
  logic [C_AW-1:0] tag_wr_q, tag_wr_d;

  // Storage arrays (no reset needed: validity is tracked by the counters)
  logic [31:0] q_instr_q [DEPTH];
  logic [31:0] q_pc_q    [DEPTH];
  logic [31:0] tag_pc_q  [DEPTH];

  // Per-cycle events
  logic          w_redirect;
  logic          w_xfer;
  logic          w_resp;
  logic          w_discard;
  logic          w_push;
  logic          w_pop;
  logic [C_CW:0] w_occupancy;

  // Jump targets are always word aligned; the low bits carry no meaning.
  logic w_unused;
  assign w_unused = ^p3_jump_target[1:0];

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  // A stalled jump is held in P3 and acted on only once the stall lifts.
  assign w_redirect  = p3_jump_taken & ~stall;

  // Credit: queued plus in-flight fetches may never exceed the queue size,
  // which guarantees a slot for every response that can come back.
  assign w_occupancy = {1'b0, count_q} + {1'b0, outstanding_q};

  assign imem_req    = ~reset & ~w_redirect & (w_occupancy < C_DEPTH_OCC);
  assign imem_addr   = fetch_pc_q;
  assign w_xfer      = imem_req & imem_ready;

  // A response landing in the redirect cycle is already wrong-path.
  assign w_resp      = imem_rvalid & ~reset;
  assign w_discard   = w_redirect | (drop_q != '0);
  assign w_push      = w_resp & ~w_discard;

  // Head presentation is purely from registers; zeroed when nothing valid.
  assign p2_instr_valid = ~reset & (count_q != '0);
  assign p2_instr       = p2_instr_valid ? q_instr_q[rd_ptr_q] : 32'd0;
  assign p2_pc          = p2_instr_valid ? q_pc_q[rd_ptr_q]    : 32'd0;

  // Any jump in P3 (stalled or not) means the head must not leave the queue.
  assign w_pop = p2_instr_valid & ~stall & ~p2_bubble & ~p3_jump_taken;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Fetch PC, outstanding counter and tag FIFO pointers
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    tag_wr_d      = tag_wr_q + C_AW'(w_xfer);
    tag_rd_d      = tag_rd_q + C_AW'(w_resp);
    outstanding_d = outstanding_q + C_CW'(w_xfer) - C_CW'(w_resp);
    if (w_redirect) begin
      fetch_pc_d = {p3_jump_target[31:2], 2'b00};
    end else if (w_xfer) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // Drop counter: on redirect every fetch still in flight after this
  // cycle's response becomes stale; a second redirect simply recounts.
  always_comb begin
    drop_d = drop_q;
    if (w_redirect) begin
      drop_d = outstanding_q - C_CW'(w_resp);
    end else if (w_resp && (drop_q != '0)) begin
      drop_d = drop_q - C_CW'(1);
    end
  end

  // Decode queue pointers and occupancy; redirect empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_redirect) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + C_AW'(w_push);
      rd_ptr_d = rd_ptr_q + C_AW'(w_pop);
      count_d  = count_q + C_CW'(w_push) - C_CW'(w_pop);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Control state with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  // Payload storage: tag the issued PC, then pair it with its returning word
  always_ff @(posedge clock) begin
    if (w_xfer) begin
      tag_pc_q[tag_wr_q] <= fetch_pc_q;
    end
    if (w_push) begin
      q_instr_q[wr_ptr_q] <= imem_rdata;
      q_pc_q[wr_ptr_q]    <= tag_pc_q[tag_rd_q];
    end
  end

  // Invariants of the credit scheme
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(imem_rvalid && (outstanding_q == '0)));
      assert (!(w_xfer && (outstanding_q == C_DEPTH_CNT)));
      assert (!(w_push && (count_q == C_DEPTH_CNT)));
      assert (!(w_pop && (count_q == '0)));
      assert (drop_q <= outstanding_q);
      assert (w_occupancy <= C_DEPTH_OCC);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ifetch
// Description : Self-checking bench for cpu_ifetch. A transaction-level model
//               (queues of fetches and decoded entries with stale flags)
//               predicts every output each cycle; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ifetch;

  localparam logic [31:0] RPC   = 32'hFFFF_0000;
  localparam int          DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] p2_instr;
  logic [31:0] p2_pc;
  logic        p2_instr_valid;
  logic        p2_bubble;
  logic        p3_jump_taken;
  logic [31:0] p3_jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  always #5 clock = ~clock;

  cpu_ifetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .p2_instr       (p2_instr),
    .p2_pc          (p2_pc),
    .p2_instr_valid (p2_instr_valid),
    .p2_bubble      (p2_bubble),
    .p3_jump_taken  (p3_jump_taken),
    .p3_jump_target (p3_jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Memory environment: accepted requests waiting for their response cycle
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int    lat;
  int    cyc;
  int    cur_out;
  int    max_out;

  // Reference model: in-flight fetches with a stale flag, and decode queue
  typedef struct { logic [31:0] addr; bit stale; } fetch_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  fetch_t      m_out[$];
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] consumed[$];

  // Values observed during the most recent cycle
  logic        last_req;
  logic [31:0] last_addr;
  logic        last_valid;
  logic [31:0] last_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // One clock cycle: memory drives its response, outputs are compared with
  // the model, then the model advances using this cycle's inputs.
  task automatic tick();
    bit     redirect;
    bit     e_req;
    bit     e_valid;
    bit     consume;
    fetch_t o;
    if (!reset && (mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    last_req   = imem_req;
    last_addr  = imem_addr;
    last_valid = p2_instr_valid;
    last_pc    = p2_pc;
    if (reset) begin
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_p2_valid", 32'(p2_instr_valid), 32'd0);
      chk("rst_p2_instr", p2_instr, 32'd0);
      chk("rst_p2_pc", p2_pc, 32'd0);
      m_pc = RPC;
      m_out.delete();
      m_q.delete();
      mem_q.delete();
      consumed.delete();
      cyc     = 0;
      cur_out = 0;
      max_out = 0;
    end else begin
      redirect = p3_jump_taken && !stall;
      e_req    = !redirect && ((m_q.size() + m_out.size()) < DEPTH);
      e_valid  = m_q.size() > 0;
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", imem_addr, m_pc);
      chk("p2_valid", 32'(p2_instr_valid), 32'(e_valid));
      chk("p2_pc", p2_pc, e_valid ? m_q[0].pc : 32'd0);
      chk("p2_instr", p2_instr, e_valid ? m_q[0].instr : 32'd0);
      consume = e_valid && !stall && !p2_bubble && !p3_jump_taken;
      if (consume) begin
        consumed.push_back(m_q[0].pc);
        void'(m_q.pop_front());
      end
      if (imem_rvalid) begin
        void'(mem_q.pop_front());
        if (m_out.size() == 0) begin
          fail_now("model_resp", "response with no fetch expected in flight");
        end else begin
          o = m_out.pop_front();
          if (!o.stale && !redirect) m_q.push_back('{pc: o.addr, instr: mem_word(o.addr)});
        end
      end
      if (redirect) begin
        m_q.delete();
        foreach (m_out[i]) m_out[i].stale = 1'b1;
        m_pc = {p3_jump_target[31:2], 2'b00};
      end
      if (e_req && imem_ready) begin
        m_out.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (imem_req && imem_ready) mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      cur_out = mem_q.size();
      if (cur_out > max_out) max_out = cur_out;
      cyc++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int l);
    reset          = 1'b1;
    stall          = 1'b0;
    p2_bubble      = 1'b0;
    p3_jump_taken  = 1'b0;
    p3_jump_target = 32'd0;
    imem_ready     = 1'b1;
    lat            = l;
    run(2);
    reset = 1'b0;
  endtask

  task automatic expect_next_valid(input string name, input logic [31:0] exp, input int budget);
    int k;
    k = 0;
    while (!p2_instr_valid && (k < budget)) begin
      tick();
      k++;
    end
    if (p2_instr_valid) begin
      chk(name, p2_pc, exp);
      chk({name, "_instr"}, p2_instr, mem_word(exp));
    end else begin
      fail_now(name, "timeout waiting for a valid instruction");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bubbled;
    int n0;
    reset          = 1'b1;
    stall          = 1'b0;
    p2_bubble      = 1'b0;
    p3_jump_taken  = 1'b0;
    p3_jump_target = 32'd0;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;
    lat            = 1;
    cyc            = 0;
    @(posedge clock);
    #1;

    // Sequential fetch at latency 1, then a one-cycle decode bubble
    do_reset(1);
    tick();
    chk("t1_req0", 32'(last_req), 32'd1);
    chk("t1_addr0", last_addr, 32'hFFFF_0000);
    tick();
    chk("t1_addr1", last_addr, 32'hFFFF_0004);
    tick();
    chk("t1_first_valid", 32'(last_valid), 32'd1);
    chk("t1_first_pc", last_pc, 32'hFFFF_0000);
    bubbled = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bubbled && p2_instr_valid && (p2_pc == 32'hFFFF_0008)) begin
        p2_bubble = 1'b1;
        tick();
        p2_bubble = 1'b0;
        bubbled   = 1'b1;
        chk("t2_replay_valid", 32'(p2_instr_valid), 32'd1);
        chk("t2_replay_pc", p2_pc, 32'hFFFF_0008);
      end else begin
        tick();
      end
    end
    if (!bubbled) fail_now("t2_bubble", "FFFF0008 never presented");
    if (consumed.size() >= 5) begin
      chk("t2_seq0", consumed[0], 32'hFFFF_0000);
      chk("t2_seq1", consumed[1], 32'hFFFF_0004);
      chk("t2_seq2", consumed[2], 32'hFFFF_0008);
      chk("t2_seq3", consumed[3], 32'hFFFF_000C);
      chk("t2_seq4", consumed[4], 32'hFFFF_0010);
    end else begin
      fail_now("t2_seq", "fewer than five instructions consumed");
    end

    // Redirect with two fetches in flight at latency 3
    do_reset(3);
    run(2);
    chk("t3_inflight", 32'(cur_out), 32'd2);
    p3_jump_taken  = 1'b1;
    p3_jump_target = 32'h0000_1003;
    tick();
    p3_jump_taken  = 1'b0;
    expect_next_valid("t3_first_pc", 32'h0000_1000, 30);
    run(6);

    // Second redirect while stale fetches are still being dropped
    do_reset(3);
    run(2);
    p3_jump_taken  = 1'b1;
    p3_jump_target = 32'h0000_1000;
    tick();
    p3_jump_target = 32'h0000_3000;
    tick();
    p3_jump_taken  = 1'b0;
    expect_next_valid("t3b_first_pc", 32'h0000_3000, 30);
    run(6);

    // Memory back-pressure: address held, queue drains
    do_reset(1);
    run(3);
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_req_held", 32'(last_req), 32'd1);
      chk("t4_addr_held", last_addr, 32'hFFFF_0008);
    end
    chk("t4_drained", 32'(last_valid), 32'd0);
    imem_ready = 1'b1;
    expect_next_valid("t4_resume_pc", 32'hFFFF_0008, 10);
    run(4);

    // Jump held under stall, acted on once when the stall lifts
    do_reset(1);
    run(3);
    stall          = 1'b1;
    p3_jump_taken  = 1'b1;
    p3_jump_target = 32'h0000_2000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_pc", last_pc, 32'hFFFF_0004);
    end
    n0    = consumed.size();
    stall = 1'b0;
    tick();
    p3_jump_taken = 1'b0;
    expect_next_valid("t5_first_pc", 32'h0000_2000, 20);
    run(10);
    if (consumed.size() >= n0 + 3) begin
      chk("t5_seq0", consumed[n0], 32'h0000_2000);
      chk("t5_seq1", consumed[n0 + 1], 32'h0000_2004);
      chk("t5_seq2", consumed[n0 + 2], 32'h0000_2008);
    end else begin
      fail_now("t5_seq", "too few instructions after redirect");
    end

    // Long response latency: credit limits in-flight fetches to DEPTH
    do_reset(10);
    run(45);
    chk("t6_max_out", 32'(max_out), 32'd2);
    if (consumed.size() >= 4) begin
      chk("t6_seq3", consumed[3], 32'hFFFF_000C);
    end else begin
      fail_now("t6_seq", "fewer than four instructions consumed");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
